// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: shares one MAC transmit byte interface between two frame sources.
//
// Round-robin arbitration at frame granularity. A granted source owns the MAC until
// its frame ends. The block enforces an inter-frame gap, aborts a grant the MAC never
// acknowledges, drives the MAC configuration pins and reports completed frames.
//
// Parameters:
//   IFG_CYCLES   idle cycles forced between frames (1..255)
//   ACK_TIMEOUT  max cycles waiting for mac_tx_ack before abort (1..65535)
//
// Ports:
//   tx_clk, reset                     clock, synchronous active-high reset
//   conf_tx_en                        MAC TX enable, 1 from the first idle cycle
//   conf_tx_jumbo_en, conf_tx_no_gen_crc  tied low
//   reqN_data/reqN_dvld               source N byte and frame valid
//   reqN_ack/reqN_abort               MAC ack forwarded to source N, abort pulse
//   mac_tx_data/mac_tx_dvld/mac_tx_ack  MAC byte interface
//   frame_sent/frame_src              completion pulse and source of last frame
//
// Optional build macro MAC_TX_ARB_STATS_EN adds saturating 16-bit counters
// stat_frames0, stat_frames1 (completed frames per source) and stat_aborts.

module mac_tx_arbiter #(
   parameter int unsigned IFG_CYCLES  = 12,
   parameter int unsigned ACK_TIMEOUT = 1000
) (
   input  logic       tx_clk,
   input  logic       reset,
   output logic       conf_tx_en,
   output logic       conf_tx_jumbo_en,
   output logic       conf_tx_no_gen_crc,
   input  logic [7:0] req0_data,
   input  logic       req0_dvld,
   output logic       req0_ack,
   output logic       req0_abort,
   input  logic [7:0] req1_data,
   input  logic       req1_dvld,
   output logic       req1_ack,
   output logic       req1_abort,
   output logic [7:0] mac_tx_data,
   output logic       mac_tx_dvld,
   input  logic       mac_tx_ack,
   output logic       frame_sent,
   output logic       frame_src
`ifdef MAC_TX_ARB_STATS_EN
   ,
   output logic [15:0] stat_frames0,
   output logic [15:0] stat_frames1,
   output logic [15:0] stat_aborts
`endif
);

   typedef enum logic [2:0] {
      StReset   = 3'd0,
      StIdle    = 3'd1,
      StWaitAck = 3'd2,
      StXfer    = 3'd3,
      StAbort   = 3'd4,
      StIfg     = 3'd5
   } state_e;

   localparam logic [15:0] IfgLast = 16'(IFG_CYCLES - 1);
   localparam logic [15:0] AckLast = 16'(ACK_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        grant_q, grant_d;
   logic        rr_q, rr_d;
   logic [15:0] cnt_q, cnt_d;
   logic        conf_q, conf_d;
   logic        sent_q, sent_d;
   logic        src_q, src_d;
   // Per source: dvld seen low since its last grant, so a stale frame is never re-granted.
   logic [1:0]  low_seen_q, low_seen_d;

   logic [1:0]  dvld_vec;
   logic [1:0]  elig;
   logic        g_dvld;
   logic        active;

   assign dvld_vec = {req1_dvld, req0_dvld};
   assign elig     = dvld_vec & low_seen_q;
   assign g_dvld   = grant_q ? req1_dvld : req0_dvld;
   assign active   = (state_q == StWaitAck) || (state_q == StXfer);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      conf_d     = 1'b1;
      sent_d     = 1'b0;
      src_d      = src_q;
      low_seen_d = low_seen_q | ~dvld_vec;
      unique case (state_q)
         StReset: state_d = StIdle;
         StIdle: begin
            if (|elig) begin
               // Both eligible: rr pointer decides; otherwise the single requester.
               grant_d             = (&elig) ? rr_q : elig[1];
               low_seen_d[grant_d] = 1'b0;
               cnt_d               = 16'd0;
               state_d             = StWaitAck;
            end
         end
         StWaitAck: begin
            if (!g_dvld) begin
               state_d = StIfg;
               cnt_d   = 16'd0;
            end else if (mac_tx_ack) begin
               // Ack wins over a coincident timeout.
               state_d = StXfer;
               cnt_d   = 16'd0;
            end else if (cnt_q == AckLast) begin
               state_d = StAbort;
               src_d   = grant_q;
               rr_d    = ~grant_q;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StXfer: begin
            if (!g_dvld) begin
               state_d = StIfg;
               cnt_d   = 16'd0;
               sent_d  = 1'b1;
               src_d   = grant_q;
               rr_d    = ~grant_q;
            end
         end
         StAbort: begin
            state_d = StIfg;
            cnt_d   = 16'd0;
         end
         StIfg: begin
            if (cnt_q == IfgLast) begin
               state_d = StIdle;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge tx_clk) begin
      if (reset) begin
         state_q    <= StReset;
         grant_q    <= 1'b0;
         rr_q       <= 1'b0;
         cnt_q      <= 16'd0;
         conf_q     <= 1'b0;
         sent_q     <= 1'b0;
         src_q      <= 1'b0;
         low_seen_q <= 2'b11;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         conf_q     <= conf_d;
         sent_q     <= sent_d;
         src_q      <= src_d;
         low_seen_q <= low_seen_d;
      end
   end

   always_comb begin
      mac_tx_dvld = active & g_dvld;
      mac_tx_data = 8'd0;
      if (active) begin
         mac_tx_data = grant_q ? req1_data : req0_data;
      end
      req0_ack   = active & ~grant_q & mac_tx_ack;
      req1_ack   = active & grant_q & mac_tx_ack;
      req0_abort = (state_q == StAbort) & ~grant_q;
      req1_abort = (state_q == StAbort) & grant_q;
   end

   assign conf_tx_en         = conf_q;
   assign conf_tx_jumbo_en   = 1'b0;
   assign conf_tx_no_gen_crc = 1'b0;
   assign frame_sent         = sent_q;
   assign frame_src          = src_q;

`ifdef MAC_TX_ARB_STATS_EN
   logic [15:0] stat_f0_q, stat_f1_q, stat_ab_q;

   always_ff @(posedge tx_clk) begin
      if (reset) begin
         stat_f0_q <= 16'd0;
         stat_f1_q <= 16'd0;
         stat_ab_q <= 16'd0;
      end else begin
         if (sent_q && !src_q && (stat_f0_q != 16'hFFFF)) stat_f0_q <= stat_f0_q + 16'd1;
         if (sent_q && src_q && (stat_f1_q != 16'hFFFF))  stat_f1_q <= stat_f1_q + 16'd1;
         if ((state_q == StAbort) && (stat_ab_q != 16'hFFFF)) stat_ab_q <= stat_ab_q + 16'd1;
      end
   end

   assign stat_frames0 = stat_f0_q;
   assign stat_frames1 = stat_f1_q;
   assign stat_aborts  = stat_ab_q;
`endif

endmodule

// File: tb/tb_mac_tx_arbiter.sv
module tb_mac_tx_arbiter;
   localparam int unsigned IFG = 12;
   localparam int unsigned TMO = 20;

   logic       tx_clk = 1'b0;
   logic       reset  = 1'b1;
   logic       conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc;
   logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
   logic       req0_dvld = 1'b0, req1_dvld = 1'b0;
   logic       req0_ack, req0_abort, req1_ack, req1_abort;
   logic [7:0] mac_tx_data;
   logic       mac_tx_dvld;
   logic       mac_tx_ack = 1'b0;
   logic       frame_sent, frame_src;
`ifdef MAC_TX_ARB_STATS_EN
   logic [15:0] stat_frames0, stat_frames1, stat_aborts;
`endif

   always #5 tx_clk = ~tx_clk;

   mac_tx_arbiter #(.IFG_CYCLES(IFG), .ACK_TIMEOUT(TMO)) dut (
      .tx_clk(tx_clk), .reset(reset),
      .conf_tx_en(conf_tx_en), .conf_tx_jumbo_en(conf_tx_jumbo_en),
      .conf_tx_no_gen_crc(conf_tx_no_gen_crc),
      .req0_data(req0_data), .req0_dvld(req0_dvld), .req0_ack(req0_ack),
      .req0_abort(req0_abort),
      .req1_data(req1_data), .req1_dvld(req1_dvld), .req1_ack(req1_ack),
      .req1_abort(req1_abort),
      .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld), .mac_tx_ack(mac_tx_ack),
      .frame_sent(frame_sent), .frame_src(frame_src)
`ifdef MAC_TX_ARB_STATS_EN
      , .stat_frames0(stat_frames0), .stat_frames1(stat_frames1), .stat_aborts(stat_aborts)
`endif
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // Reference model state and scoreboard queues.
   logic [7:0] fbuf [2][64];
   int         flen [2];
   bit         rr_m = 1'b0;
   int         frames0_m = 0, frames1_m = 0, aborts_m = 0;
   bit         exp_src_q[$];
   int         exp_len_q[$];
   logic [7:0] exp_byte_q[$];
   bit         sent_q[$];
   bit         abort_q[$];

   task automatic gen(input bit s, input int len);
      flen[s] = len;
      for (int i = 0; i < len; i++) fbuf[s][i] = 8'($urandom);
   endtask

   task automatic push_frame(input bit s);
      exp_src_q.push_back(s);
      exp_len_q.push_back(flen[s]);
      for (int i = 0; i < flen[s]; i++) exp_byte_q.push_back(fbuf[s][i]);
      sent_q.push_back(s);
      if (s) frames1_m++; else frames0_m++;
      rr_m = ~s;
   endtask

   // Frame-level round robin: simultaneous requesters served pointer-first.
   task automatic serve(input bit r0, input bit r1);
      bit f;
      if (r0 && r1) begin
         f = rr_m;
         push_frame(f);
         push_frame(~f);
      end else if (r0) begin
         push_frame(1'b0);
      end else if (r1) begin
         push_frame(1'b1);
      end
   endtask

   // MAC model: acks the first byte after a delay; mac_never suppresses the ack.
   bit mac_never = 1'b0;
   int mac_fixed = 0;
   int mac_wcnt  = 0;
   int mac_delay = 1;
   bit mac_acked = 1'b0;

   always begin
      @(posedge tx_clk);
      #2;
      mac_tx_ack = 1'b0;
      if (!mac_tx_dvld) begin
         mac_acked = 1'b0;
         mac_wcnt  = 0;
      end else if (!mac_acked) begin
         mac_wcnt++;
         if (mac_wcnt == 1) mac_delay = (mac_fixed > 0) ? mac_fixed : int'($urandom_range(1, 6));
         if (!mac_never && mac_wcnt >= mac_delay) begin
            mac_tx_ack = 1'b1;
            mac_acked  = 1'b1;
         end
      end
   end

   task automatic set_src(input bit s, input logic v, input logic [7:0] d);
      if (s) begin
         req1_dvld = v;
         req1_data = d;
      end else begin
         req0_dvld = v;
         req0_data = d;
      end
   endtask

   int hold_seen = 0;

   // Source driver: hold byte 0 until ack, then one byte per cycle; on abort, keep
   // dvld high for a while to show the stale frame is not re-granted.
   task automatic drive(input bit s);
      int  idx = 0;
      int  waitc = 0;
      bit  started = 1'b0;
      bit  a, ab;
      set_src(s, 1'b1, fbuf[s][0]);
      forever begin
         @(negedge tx_clk);
         a  = s ? req1_ack : req0_ack;
         ab = s ? req1_abort : req0_abort;
         @(posedge tx_clk);
         #1;
         if (reset) begin
            set_src(s, 1'b0, 8'd0);
            return;
         end
         if (ab) begin
            repeat (30) begin
               @(negedge tx_clk);
               if (mac_tx_dvld) hold_seen++;
            end
            @(posedge tx_clk);
            #1;
            set_src(s, 1'b0, 8'd0);
            return;
         end
         if (started || a) begin
            started = 1'b1;
            idx++;
            if (idx >= flen[s]) begin
               set_src(s, 1'b0, 8'd0);
               return;
            end
            set_src(s, 1'b1, fbuf[s][idx]);
         end else begin
            waitc++;
            if (waitc > 2000) begin
               check("ack_wait_bound", waitc, 0);
               set_src(s, 1'b0, 8'd0);
               return;
            end
         end
      end
   endtask

   // Monitor: collects MAC-side frames and pulses, compares against the scoreboard.
   logic [7:0] cur_q[$];
   bit         in_acked = 1'b0;
   bit         prev_dvld = 1'b0;
   bit         cur_src = 1'b0;
   int         gap = -1;
   int         last_gap = -1;
   int         wait_len = 0;

   always @(negedge tx_clk) begin
      if (reset) begin
         cur_q.delete();
         in_acked = 1'b0;
         gap      = -1;
         wait_len = 0;
      end else begin
         if (mac_tx_dvld) begin
            if (!in_acked && !prev_dvld) begin
               if (gap >= 0) begin
                  check("ifg_gap_min", 32'(gap >= int'(IFG + 2)), 1);
                  last_gap = gap;
               end
               gap      = -1;
               wait_len = 0;
            end
            if (in_acked || mac_tx_ack) begin
               if (!in_acked) begin
                  check("ack_route_onehot", 32'(req0_ack ^ req1_ack), 1);
                  cur_src = req1_ack;
               end
               in_acked = 1'b1;
               cur_q.push_back(mac_tx_data);
            end else begin
               wait_len++;
            end
         end else if (in_acked) begin
            if (exp_src_q.size() == 0) begin
               check("unexpected_frame", 1, 0);
            end else begin
               bit         es;
               int         el, nbad;
               logic [7:0] eb;
               es   = exp_src_q.pop_front();
               el   = exp_len_q.pop_front();
               nbad = 0;
               check("frame_source", 32'(cur_src), 32'(es));
               check("frame_length", cur_q.size(), el);
               for (int i = 0; i < el; i++) begin
                  eb = (exp_byte_q.size() > 0) ? exp_byte_q.pop_front() : 8'd0;
                  if (i >= cur_q.size() || cur_q[i] !== eb) nbad++;
               end
               check("frame_bytes", nbad, 0);
            end
            cur_q.delete();
            in_acked = 1'b0;
            gap      = 1;
         end else if (gap >= 0) begin
            gap++;
         end
         if (frame_sent) begin
            if (sent_q.size() == 0) check("unexpected_frame_sent", 1, 0);
            else check("frame_sent_src", 32'(frame_src), 32'(sent_q.pop_front()));
         end
         if (req0_abort || req1_abort) begin
            check("abort_onehot", 32'(req0_abort & req1_abort), 0);
            if (abort_q.size() == 0) begin
               check("unexpected_abort", 1, 0);
            end else begin
               bit s;
               s = abort_q.pop_front();
               check("abort_pin_src", 32'(req1_abort), 32'(s));
               check("abort_frame_src", 32'(frame_src), 32'(s));
               check("abort_wait_cycles", wait_len, int'(TMO));
            end
         end
      end
      prev_dvld = mac_tx_dvld;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bound;
      // Reset state.
      repeat (3) @(negedge tx_clk);
      check("rst_conf_tx_en", 32'(conf_tx_en), 0);
      check("rst_mac_tx_dvld", 32'(mac_tx_dvld), 0);
      check("rst_mac_tx_data", 32'(mac_tx_data), 0);
      check("rst_frame_sent", 32'(frame_sent), 0);
      check("rst_frame_src", 32'(frame_src), 0);
      check("rst_acks", 32'({req0_ack, req1_ack}), 0);
      check("rst_aborts", 32'({req0_abort, req1_abort}), 0);
      check("conf_jumbo_crc", 32'({conf_tx_jumbo_en, conf_tx_no_gen_crc}), 0);
      #1 reset = 1'b0;
      @(negedge tx_clk);
      check("conf_tx_en_after_reset", 32'(conf_tx_en), 1);
      @(posedge tx_clk);
      #1;

      // Single source, 60 bytes, ack 3 cycles after dvld.
      mac_fixed = 3;
      gen(1'b0, 60);
      push_frame(1'b0);
      drive(1'b0);
      mac_fixed = 0;
      repeat (2) @(posedge tx_clk);
      #1;

      // Three simultaneous pairs: served pointer-first, gap exactly IFG+2 low cycles.
      for (int p = 0; p < 3; p++) begin
         gen(1'b0, int'($urandom_range(5, 20)));
         gen(1'b1, int'($urandom_range(5, 20)));
         serve(1'b1, 1'b1);
         fork
            drive(1'b0);
            drive(1'b1);
         join
         check("contention_gap", last_gap, int'(IFG + 2));
         repeat (2) @(posedge tx_clk);
         #1;
      end

      // Reset in the middle of a 60-byte frame at byte 30.
      gen(1'b0, 60);
      fork
         drive(1'b0);
         begin
            bound = 0;
            do begin
               @(negedge tx_clk);
               #1;
               bound++;
            end while (cur_q.size() < 30 && bound < 500);
            check("reset_mid_reach_byte30", 32'(cur_q.size()), 30);
            reset = 1'b1;
         end
      join
      @(negedge tx_clk);
      check("midrst_mac_tx_dvld", 32'(mac_tx_dvld), 0);
      check("midrst_conf_tx_en", 32'(conf_tx_en), 0);
      check("midrst_pulses", 32'({frame_sent, req0_abort, req1_abort}), 0);
      #1 reset = 1'b0;
      rr_m      = 1'b0;
      frames0_m = 0;
      frames1_m = 0;
      aborts_m  = 0;
      gen(1'b1, 10);
      push_frame(1'b1);
      fork
         drive(1'b1);
         begin
            @(negedge tx_clk);
            check("postrst_conf_tx_en", 32'(conf_tx_en), 1);
            check("postrst_idle_dvld", 32'(mac_tx_dvld), 0);
            @(negedge tx_clk);
            check("postrst_grant_dvld", 32'(mac_tx_dvld), 1);
         end
      join
      repeat (2) @(posedge tx_clk);
      #1;

      // Timeout: MAC never acks source 1.
      mac_never = 1'b1;
      gen(1'b1, 10);
      abort_q.push_back(1'b1);
      aborts_m++;
      rr_m = 1'b0;
      hold_seen = 0;
      drive(1'b1);
      check("no_regrant_stale", hold_seen, 0);
      mac_never = 1'b0;
      repeat (2) @(posedge tx_clk);
      #1;

      // Ack on the last cycle before timeout wins.
      mac_fixed = int'(TMO);
      gen(1'b0, 8);
      push_frame(1'b0);
      drive(1'b0);
      mac_fixed = 0;
      repeat (2) @(posedge tx_clk);
      #1;

      // Randomized rounds.
      for (int r = 0; r < 40; r++) begin
         int rq;
         rq = int'($urandom_range(1, 3));
         gen(1'b0, int'($urandom_range(1, 24)));
         gen(1'b1, int'($urandom_range(1, 24)));
         serve(rq[0], rq[1]);
         fork
            begin
               if (rq[0]) drive(1'b0);
            end
            begin
               if (rq[1]) drive(1'b1);
            end
         join
         repeat (1 + $urandom_range(0, 3)) @(posedge tx_clk);
         #1;
      end

      repeat (IFG + 6) @(negedge tx_clk);
      check("sb_frames_left", exp_src_q.size(), 0);
      check("sb_sent_left", sent_q.size(), 0);
      check("sb_aborts_left", abort_q.size(), 0);
`ifdef MAC_TX_ARB_STATS_EN
      check("stat_frames0", 32'(stat_frames0), frames0_m);
      check("stat_frames1", 32'(stat_frames1), frames1_m);
      check("stat_aborts", 32'(stat_aborts), aborts_m);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
